// File: rtl/mips_multicycle_control_fsm.sv
// Multicycle control sequencer for data_tract_mips: latches the instruction, walks it through
// FETCH/DECODE/EXEC/MEM/WB and drives registered datapath controls, a PC-step strobe and a retire count.
module mips_multicycle_control_fsm #(
   parameter logic [5:0] ALU_ADD = 6'b000010,
   parameter logic [5:0] ALU_SUB = 6'b000110,
   parameter logic [5:0] ALU_AND = 6'b000000,
   parameter logic [5:0] ALU_OR  = 6'b000001,
   parameter logic [5:0] ALU_SLT = 6'b000111
) (
   input  logic        in_clk,
   input  logic        in_reset,
   input  logic        in_run,
   input  logic [31:0] in_instruction,
   output logic        out_pc_step,
   output logic        out_is_jump,
   output logic        out_r_1_en,
   output logic        out_r_2_en,
   output logic        out_w_en,
   output logic        out_reg_dst,
   output logic        out_alu_src,
   output logic        out_is_branch,
   output logic        out_mem_write,
   output logic        out_mem_to_reg,
   output logic [5:0]  out_alu_control,
   output logic        out_busy,
   output logic        out_illegal,
   output logic [31:0] out_retired
);

   typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;
   typedef enum logic [2:0] {ClsR, ClsAddi, ClsLw, ClsSw, ClsBeq, ClsJ, ClsIllegal} cls_e;

   typedef struct packed {
      logic       pc_step;
      logic       is_jump;
      logic       r_1_en;
      logic       r_2_en;
      logic       w_en;
      logic       reg_dst;
      logic       alu_src;
      logic       is_branch;
      logic       mem_write;
      logic       mem_to_reg;
      logic [5:0] alu_control;
      logic       busy;
      logic       illegal;
   } ctrl_t;

   state_e      state_q, state_d;
   logic [31:0] ir_q, ir_d;
   ctrl_t       ctrl_q, ctrl_d;
   logic [31:0] retired_q;
   cls_e        cls;
   logic [5:0]  alu_sel;
   state_e      boundary;

   // Register fields are consumed by the datapath, not by this sequencer.
   logic unused_ir;
   assign unused_ir = ^ir_q[25:6];

   always_comb begin
      cls     = ClsIllegal;
      alu_sel = ALU_AND;
      case (ir_q[31:26])
         6'h00: begin
            case (ir_q[5:0])
               6'h20: begin cls = ClsR; alu_sel = ALU_ADD; end
               6'h22: begin cls = ClsR; alu_sel = ALU_SUB; end
               6'h24: begin cls = ClsR; alu_sel = ALU_AND; end
               6'h25: begin cls = ClsR; alu_sel = ALU_OR;  end
               6'h2A: begin cls = ClsR; alu_sel = ALU_SLT; end
               default: ;
            endcase
         end
         6'h23:   begin cls = ClsLw;   alu_sel = ALU_ADD; end
         6'h2B:   begin cls = ClsSw;   alu_sel = ALU_ADD; end
         6'h04:   begin cls = ClsBeq;  alu_sel = ALU_SUB; end
         6'h08:   begin cls = ClsAddi; alu_sel = ALU_ADD; end
         6'h02:   begin cls = ClsJ;    alu_sel = ALU_AND; end
         default: ;
      endcase
   end

   // in_run is only looked at when an instruction retires or while idle.
   always_comb begin
      boundary = in_run ? StFetch : StIdle;
      state_d  = state_q;
      ir_d     = ir_q;
      case (state_q)
         StIdle:   if (in_run) state_d = StFetch;
         StFetch: begin
            ir_d    = in_instruction;
            state_d = StDecode;
         end
         StDecode: state_d = (cls == ClsIllegal) ? StHalt : StExec;
         StExec: begin
            case (cls)
               ClsLw, ClsSw:  state_d = StMem;
               ClsBeq, ClsJ:  state_d = boundary;
               default:       state_d = StWb;
            endcase
         end
         StMem:    state_d = (cls == ClsSw) ? boundary : StWb;
         StWb:     state_d = boundary;
         StHalt:   state_d = StHalt;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs are computed for the state being entered and registered alongside it.
   always_comb begin
      ctrl_d         = '0;
      ctrl_d.busy    = !(state_d inside {StIdle, StHalt});
      ctrl_d.illegal = (state_d == StHalt);
      if (state_d inside {StExec, StMem, StWb}) begin
         ctrl_d.alu_control = alu_sel;
         ctrl_d.alu_src     = cls inside {ClsAddi, ClsLw, ClsSw};
         ctrl_d.reg_dst     = (cls == ClsR);
      end
      case (state_d)
         StDecode: begin
            ctrl_d.r_1_en = 1'b1;
            ctrl_d.r_2_en = 1'b1;
         end
         StExec: begin
            ctrl_d.is_branch = (cls == ClsBeq);
            ctrl_d.is_jump   = (cls == ClsJ);
            ctrl_d.pc_step   = cls inside {ClsBeq, ClsJ};
         end
         StMem: begin
            ctrl_d.mem_write = (cls == ClsSw);
            ctrl_d.pc_step   = (cls == ClsSw);
         end
         StWb: begin
            ctrl_d.w_en       = 1'b1;
            ctrl_d.pc_step    = 1'b1;
            ctrl_d.mem_to_reg = (cls == ClsLw);
         end
         default: ;
      endcase
   end

   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         state_q   <= StIdle;
         ir_q      <= '0;
         ctrl_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         ctrl_q  <= ctrl_d;
         if (ctrl_d.pc_step) retired_q <= retired_q + 32'd1;
      end
   end

   assign out_pc_step     = ctrl_q.pc_step;
   assign out_is_jump     = ctrl_q.is_jump;
   assign out_r_1_en      = ctrl_q.r_1_en;
   assign out_r_2_en      = ctrl_q.r_2_en;
   assign out_w_en        = ctrl_q.w_en;
   assign out_reg_dst     = ctrl_q.reg_dst;
   assign out_alu_src     = ctrl_q.alu_src;
   assign out_is_branch   = ctrl_q.is_branch;
   assign out_mem_write   = ctrl_q.mem_write;
   assign out_mem_to_reg  = ctrl_q.mem_to_reg;
   assign out_alu_control = ctrl_q.alu_control;
   assign out_busy        = ctrl_q.busy;
   assign out_illegal     = ctrl_q.illegal;
   assign out_retired     = retired_q;

endmodule
